// File: rtl/ahb_arb_pkg.sv
// Shared types for the AHB-lite request arbiter: transfer/size/burst encodings
// and the data-phase state enumeration.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        DP_IDLE = 2'b00,
        DP_BUSY = 2'b01,
        DP_ERR  = 2'b10
    } dp_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping, returned both as a one-hot grant and as an index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic [IDX_W-1:0] cand_idx [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = IDX_W'((int'(ptr) + gi) % NUM_REQ);
        end
    endgenerate

    // Scan from the farthest candidate back so the nearest one wins.
    always_comb begin
        any       = 1'b0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[cand_idx[i]]) begin
                any       = 1'b1;
                grant_idx = cand_idx[i];
            end
        end
        grant = any ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/ahb_lite_req_arbiter.sv
// Round-robin sharing of one AHB-lite master port between NUM_REQ single-transfer
// requesters. Define AHB_ARB_LOCK_EN to add req_lock/hmastlock locked sequences.
module ahb_lite_req_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*3-1:0]      req_size,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         haddr,
    output logic [1:0]                htrans,
    output logic                      hwrite,
    output logic [2:0]                hsize,
    output logic [2:0]                hburst,
    output logic [DATA_W-1:0]         hwdata,
    input  logic [DATA_W-1:0]         hrdata,
    input  logic                      hready,
`ifdef AHB_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic                      hmastlock,
`endif
    input  logic                      hresp
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [2:0]        size_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign size_arr[gi]  = req_size[gi*3 +: 3];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [IDX_W-1:0]   rr_ptr_reg;
    logic               hold_reg;
    logic [IDX_W-1:0]   hold_idx_reg;
    dp_state_e          dp_state_reg, dp_state_next;
    logic [IDX_W-1:0]   owner_reg;
    logic               dp_write_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [NUM_REQ-1:0] rsp_valid_reg;
    logic [DATA_W-1:0]  rsp_rdata_reg;
    logic               rsp_err_reg;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   addr_idx;
    logic               addr_act;
    logic               accept;
    logic               err_start;
    logic               complete;
    logic               complete_err;
    logic [IDX_W-1:0]   ptr_inc;
    logic [IDX_W-1:0]   next_ptr;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req       (arb_req),
        .ptr       (rr_ptr_reg),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // A stalled address phase keeps its requester; otherwise the grant is live.
    // While the second error cycle runs, the bus is forced to IDLE.
    assign addr_idx  = hold_reg ? hold_idx_reg : pick_idx;
    assign addr_act  = !hreset && (dp_state_reg != DP_ERR) && (hold_reg || pick_any);
    assign accept    = addr_act && hready;
    assign err_start = (dp_state_reg == DP_BUSY) && !hready && hresp;
    assign ptr_inc   = (addr_idx == IDX_W'(NUM_REQ - 1)) ? '0 : addr_idx + 1'b1;

    assign htrans    = addr_act ? NONSEQ : IDLE;
    assign haddr     = addr_act ? addr_arr[addr_idx] : '0;
    assign hwrite    = addr_act ? req_write[addr_idx] : 1'b0;
    assign hsize     = addr_act ? size_arr[addr_idx] : 3'b000;
    assign hburst    = HBURST_SINGLE;
    assign hwdata    = wdata_reg;
    assign req_ready = accept ? (NUM_REQ'(1) << addr_idx) : '0;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

`ifdef AHB_ARB_LOCK_EN
    logic             lock_reg;
    logic [IDX_W-1:0] lock_idx_reg;

    // A locked owner is the only requester visible to the picker.
    assign arb_req   = lock_reg ? (req_valid & (NUM_REQ'(1) << lock_idx_reg)) : req_valid;
    assign next_ptr  = req_lock[addr_idx] ? addr_idx : ptr_inc;
    assign hmastlock = addr_act && req_lock[addr_idx];

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
        end else if (accept) begin
            lock_reg     <= req_lock[addr_idx];
            lock_idx_reg <= addr_idx;
        end
    end
`else
    assign arb_req  = req_valid;
    assign next_ptr = ptr_inc;
`endif

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            rr_ptr_reg   <= '0;
            hold_reg     <= 1'b0;
            hold_idx_reg <= '0;
        end else begin
            if (err_start) begin
                hold_reg <= 1'b0;
            end else if (addr_act && !hready) begin
                hold_reg     <= 1'b1;
                hold_idx_reg <= addr_idx;
            end else begin
                hold_reg <= 1'b0;
            end
            if (accept) begin
                rr_ptr_reg <= next_ptr;
            end
        end
    end

    always_comb begin
        dp_state_next = dp_state_reg;
        complete      = 1'b0;
        complete_err  = 1'b0;
        case (dp_state_reg)
            DP_IDLE: begin
                if (accept) dp_state_next = DP_BUSY;
            end
            DP_BUSY: begin
                if (hready) begin
                    // hresp with hready here is a slave protocol slip; finish as error.
                    complete      = 1'b1;
                    complete_err  = hresp;
                    dp_state_next = accept ? DP_BUSY : DP_IDLE;
                end else if (hresp) begin
                    dp_state_next = DP_ERR;
                end
            end
            DP_ERR: begin
                if (hready) begin
                    complete      = 1'b1;
                    complete_err  = 1'b1;
                    dp_state_next = DP_IDLE;
                end
            end
            default: dp_state_next = DP_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            dp_state_reg  <= DP_IDLE;
            owner_reg     <= '0;
            dp_write_reg  <= 1'b0;
            wdata_reg     <= '0;
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            dp_state_reg <= dp_state_next;
            if (accept) begin
                owner_reg    <= addr_idx;
                dp_write_reg <= req_write[addr_idx];
                wdata_reg    <= wdata_arr[addr_idx];
            end
            rsp_valid_reg <= complete ? (NUM_REQ'(1) << owner_reg) : '0;
            if (complete) begin
                rsp_err_reg   <= complete_err;
                rsp_rdata_reg <= (complete_err || dp_write_reg) ? '0 : hrdata;
            end
        end
    end

endmodule

// File: doc/ahb_lite_req_arbiter.md
Name: ahb_lite_req_arbiter

Overview:
- Shares the single AHB-lite master port between NUM_REQ independent requesters.
- Each requester issues single transfers over a valid/ready handshake.
- Block arbitrates round-robin and drives the pipelined AHB-lite address and data phases, honouring hready wait states and two-cycle hresp errors.
- Returns read data and error status to the owning requester. Sits between testbench/agent-side traffic sources and the AHB-lite slave.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width (32 or 64)

Ports:
hclk  in  1  bus clock
hreset  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot pulse: request accepted onto bus
req_addr  in  NUM_REQ*ADDR_W  packed request addresses
req_write  in  NUM_REQ  1=write
req_size  in  NUM_REQ*3  HSIZE encoding
req_wdata  in  NUM_REQ*DATA_W  packed write data
rsp_valid  out  NUM_REQ  one-hot pulse: transfer completed
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
rsp_err  out  1  1=ERROR response, valid with rsp_valid
haddr  out  ADDR_W  AHB address
htrans  out  2  IDLE(00) or NONSEQ(10) only
hwrite  out  1  AHB write
hsize  out  3  AHB size
hburst  out  3  constant SINGLE (000)
hwdata  out  DATA_W  AHB write data
hrdata  in  DATA_W  AHB read data
hready  in  1  transfer done / slot free
hresp  in  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (hreset=1, async): htrans=IDLE; haddr, hwrite, hsize, hwdata, rsp_rdata=0; req_ready, rsp_valid, rsp_err=0; rr pointer=0; data-phase state DP_IDLE.
- Address phase:
  - When no address is held, arbiter picks the first valid requester at or after rr pointer (wrapping) and drives NONSEQ with its addr/write/size in the same cycle (combinational grant, registered outputs avoided only for grant select).
  - Address is "accepted" at a posedge with hready=1; req_ready[g] pulses in that cycle; rr pointer moves to g+1 mod NUM_REQ.
  - While hready=0 the address phase and grant are frozen (no re-arbitration, no change of haddr/htrans).
  - No valid requests: htrans=IDLE.
- Data phase FSM:
  - DP_IDLE -> DP_BUSY on accepted address; capture owner index, write flag, wdata. hwdata driven from the capture register for the whole data phase.
  - DP_BUSY, hready=1, hresp=0: rsp_valid[owner]=1 for one cycle in the next cycle (registered), rsp_rdata=hrdata (reads) or 0 (writes), rsp_err=0. Go to DP_BUSY if a new address is accepted in the same cycle, else DP_IDLE.
  - DP_BUSY, hready=0, hresp=1: go to DP_ERR. Pending address phase is converted to IDLE in the next cycle; its requester gets no req_ready and is re-arbitrated later.
  - DP_ERR, hready=1, hresp=1: rsp_valid[owner]=1, rsp_err=1 -> DP_IDLE.
  - hresp=1 with hready=1 while in DP_BUSY (protocol violation): treated as error completion.
- Back-to-back: one transfer per cycle sustainable with zero wait states.
- Latency: rsp_valid one cycle after the data-phase hready; minimum 2 cycles from req_ready.
- Requester must hold req_* stable while valid and not ready. Dropping valid before ready is permitted only while its address is not yet driven.
- Reset mid-transfer: all state cleared; in-flight transfers produce no rsp_valid.

Optional Feature:
- AHB_ARB_LOCK_EN: adds input req_lock[NUM_REQ] and output hmastlock.
  - When the owner's accepted request has req_lock=1, the grant stays with that requester (rr pointer not advanced) until it issues a request with req_lock=0. hmastlock mirrors the lock of the current address phase.
  - Without the macro: no lock ports; pure round-robin.

Decomposition:
- Shared package ahb_arb_pkg: htrans_e (IDLE, BUSY, NONSEQ, SEQ), hsize constants, hburst SINGLE, dp_state_e (DP_IDLE, DP_BUSY, DP_ERR).
- Sub-module rr_arbiter: parameterised NUM_REQ round-robin picker (req vector + pointer in, one-hot grant + index out).

Test Plan:
- Single write, req 0, addr 0x100, wdata 0xDEADBEEF, hready=1 -> NONSEQ at cycle 0; hwdata=0xDEADBEEF at cycle 1; rsp_valid[0] at cycle 2; rsp_err=0.
- All 4 requesters valid continuously, hready=1 -> grants 0,1,2,3,0…; one transfer per cycle; no requester granted twice before the others.
- Read req 2, addr 0x40, slave inserts 3 wait states then hrdata=0x12345678 -> haddr/htrans frozen during waits; rsp_valid[2] with rsp_rdata=0x12345678.
- Error: read req 1 followed by pending req 3; slave gives hresp=1/hready=0 then hresp=1/hready=1 -> htrans=IDLE in the second cycle; rsp_err=1 on rsp_valid[1]; req 3 re-issued afterwards and completes OKAY.
- Assert hreset during data phase of req 0 -> outputs return to reset values immediately; no rsp_valid; next grant starts from requester 0.
- (AHB_ARB_LOCK_EN) req 1 issues 3 locked + 1 unlocked while req 0 valid -> four consecutive grants to 1; hmastlock=1 for the first three; then grant 0.
